// File: rtl/fsm_pulse_sched_pkg.sv
// fsm_pulse_sched_pkg: shared state encoding, levels and default parameters
// Used by fsm_pulse_sched and rr_arbiter.
package fsm_pulse_sched_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FIRE    = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int DEF_NUM_REQ          = 4;
    localparam int DEF_PULSES_PER_GRANT = 2;
    localparam int DEF_TIMEOUT          = 4;

endpackage

// File: rtl/fsm_pulse_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot pick with a registered rotating pointer
// Ports: clk, reset (sync, active-high), req_i (requests), adv_i (advance strobe),
//        cur_i (one-hot index being retired), pick_o (one-hot winner, combinational).
module rr_arbiter
    import fsm_pulse_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    input  logic [NUM_REQ-1:0] cur_i,
    output logic [NUM_REQ-1:0] pick_o
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] hi, lo;

    // Scanning downwards leaves the lowest set bit in lo and the lowest set bit
    // at or above the pointer in hi; hi wins, lo provides the wrap-around.
    always_comb begin
        hi    = '0;
        lo    = '0;
        ptr_d = ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo    = '0;
                lo[i] = 1'b1;
                if (i >= int'(ptr_q)) begin
                    hi    = '0;
                    hi[i] = 1'b1;
                end
            end
            if (adv_i && cur_i[i]) ptr_d = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
        end
        pick_o = |hi ? hi : lo;
    end

    always_ff @(posedge clk) begin
        ptr_q <= reset ? '0 : ptr_d;
    end

endmodule

// File: rtl/fsm_pulse_sched.sv
// fsm_pulse_sched: round-robin scheduler sharing one pulse FSM between requesters
// Ports: clk, reset (sync, active-high), req (level requests), fsm_data (returned pulse),
//        err_clr (clears sticky err), fsm_enable (to pulse FSM), gnt (one-hot grant),
//        done (1-cycle completion strobe), err (sticky error), busy (not idle).
module fsm_pulse_sched
    import fsm_pulse_sched_pkg::*;
#(
    parameter int NUM_REQ          = DEF_NUM_REQ,
    parameter int PULSES_PER_GRANT = DEF_PULSES_PER_GRANT,
    parameter int TIMEOUT          = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               fsm_data,
    input  logic               err_clr,
    output logic               fsm_enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               err,
    output logic               busy
);

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, pick;
    logic [CNT_W-1:0]   cnt_q, cnt_d, to_q, to_d;
    logic               err_q, err_d, err_set;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req),
        .adv_i  (state_q == S_DONE),
        .cur_i  (gnt_q),
        .pick_o (pick)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        err_set = LOW;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    cnt_d   = CNT_W'(PULSES_PER_GRANT);
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                cnt_d   = cnt_q - 1'b1;
                to_d    = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (fsm_data) begin
                    state_d = S_WAIT_LO;
                end else begin
                    to_d = to_q + 1'b1;
                    if (to_d == CNT_W'(TIMEOUT)) begin
                        err_set = HIGH;
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT_LO: begin
                // Data still high here means the pulse was wider than one cycle.
                if (fsm_data) begin
                    err_set = HIGH;
                    state_d = S_DONE;
                end else begin
                    state_d = (cnt_q != '0) ? S_FIRE : S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new error outranks a simultaneous clear.
        err_d = err_set ? HIGH : (err_clr ? LOW : err_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            err_q   <= LOW;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign fsm_enable = (state_q == S_FIRE);
    assign gnt        = gnt_q;
    assign done       = (state_q == S_DONE) ? gnt_q : '0;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fsm_pulse_sched.sv
// tb_fsm_pulse_sched: directed self-checking bench with a stub pulse FSM
module tb_fsm_pulse_sched;

    logic       clk = 1'b0;
    logic       reset, fsm_data, err_clr, fsm_enable, err, busy;
    logic [3:0] req, gnt, done;
    logic [1:0] mode;
    logic [2:0] sr;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    fsm_pulse_sched #(.NUM_REQ(4), .PULSES_PER_GRANT(2), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .fsm_data   (fsm_data),
        .err_clr    (err_clr),
        .fsm_enable (fsm_enable),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    // Stub pulse FSM: mode 0 normal 1-cycle pulse at enable+2, 1 never, 2 two cycles wide.
    always @(posedge clk) sr <= reset ? 3'b000 : {sr[1:0], fsm_enable};
    assign fsm_data = (mode == 2'd0) ? sr[1] : (mode == 2'd2) ? (sr[1] | sr[2]) : 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        err_clr = 1'b0;
        mode    = 2'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 4'b1111;
        err_clr = 1'b0;
        mode    = 2'd0;
        tick();
        tick();
        checks++;
        if ({fsm_enable, gnt, done, err, busy} !== 11'b0) begin
            errors++;
            $display("FAIL reset: outputs=%b expected=%b", {fsm_enable, gnt, done, err, busy}, 11'b0);
        end
        req   = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [10:0] exp;
        do_reset();
        req = 4'b0001;
        checks++;
        if ({fsm_enable, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single c0: en,busy=%b expected=00", {fsm_enable, busy});
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp = {1'(c == 1 || c == 5), (c <= 9) ? 4'b0001 : 4'b0000,
                   (c == 9) ? 4'b0001 : 4'b0000, 1'(c <= 9), 1'b0};
            checks++;
            if ({fsm_enable, gnt, done, busy, err} !== exp) begin
                errors++;
                $display("FAIL single c%0d: en,gnt,done,busy,err=%b expected=%b", c,
                         {fsm_enable, gnt, done, busy, err}, exp);
            end
            if (c == 2) req = '0;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg, ed;
        logic       ee;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 49; c++) begin
            tick();
            eg = (c % 10 == 0) ? 4'b0000 : 4'(1 << ((c / 10) % 4));
            ed = (c % 10 == 9) ? eg : 4'b0000;
            ee = (c % 10 == 1) || (c % 10 == 5);
            checks++;
            if ({gnt, done, fsm_enable} !== {eg, ed, ee} || !$onehot0(gnt)) begin
                errors++;
                $display("FAIL rr c%0d: gnt,done,en=%b expected=%b", c, {gnt, done, fsm_enable}, {eg, ed, ee});
            end
        end
        req = '0;
    endtask

    task automatic test_wrap();
        logic [3:0] eg, ed;
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 21; c++) begin
            tick();
            eg = (c <= 9) ? 4'b0100 : (c == 10) ? 4'b0000 : (c <= 19) ? 4'b0001 :
                 (c == 20) ? 4'b0000 : 4'b0100;
            ed = (c == 9) ? 4'b0100 : (c == 19) ? 4'b0001 : 4'b0000;
            checks++;
            if ({gnt, done} !== {eg, ed}) begin
                errors++;
                $display("FAIL wrap c%0d: gnt,done=%b expected=%b", c, {gnt, done}, {eg, ed});
            end
            if (c == 9) req = 4'b0101;
        end
        req = '0;
    endtask

    task automatic test_timeout();
        int en_cnt = 0;
        do_reset();
        mode = 2'd1;
        req  = 4'b0011;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c <= 6) en_cnt += int'(fsm_enable);
            if (c == 5) begin
                checks++;
                if ({err, done} !== 5'b0) begin
                    errors++;
                    $display("FAIL timeout c5: err,done=%b expected=00000", {err, done});
                end
            end
            if (c == 6) begin
                checks++;
                if ({err, done} !== 5'b1_0001 || en_cnt != 1) begin
                    errors++;
                    $display("FAIL timeout c6: err,done=%b enables=%0d expected=10001 enables=1",
                             {err, done}, en_cnt);
                end
                mode = 2'd0;
            end
            if (c == 7) begin
                checks++;
                if ({busy, gnt} !== 5'b0) begin
                    errors++;
                    $display("FAIL timeout c7: busy,gnt=%b expected=00000", {busy, gnt});
                end
            end
            if (c == 8) begin
                checks++;
                if ({gnt, fsm_enable} !== 5'b0010_1) begin
                    errors++;
                    $display("FAIL timeout next grant: gnt,en=%b expected=00101", {gnt, fsm_enable});
                end
            end
            if (c == 16) begin
                checks++;
                if ({done, err} !== 5'b0010_1) begin
                    errors++;
                    $display("FAIL timeout next done: done,err=%b expected=00101", {done, err});
                end
            end
        end
        req = '0;
    endtask

    task automatic test_wide_pulse();
        int en_cnt = 0;
        do_reset();
        mode = 2'd2;
        req  = 4'b0001;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c <= 5) en_cnt += int'(fsm_enable);
            if (c == 1) req = '0;
            if (c == 4) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL wide c4: err=%b expected=0", err);
                end
            end
            if (c == 5) begin
                checks++;
                if ({err, done} !== 5'b1_0001 || en_cnt != 1) begin
                    errors++;
                    $display("FAIL wide abort: err,done=%b enables=%0d expected=10001 enables=1",
                             {err, done}, en_cnt);
                end
                req = 4'b0001;
            end
            if (c == 6) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL wide idle: busy=%b expected=0", busy);
                end
            end
            if (c == 7) begin
                checks++;
                if ({fsm_enable, gnt} !== 5'b1_0001) begin
                    errors++;
                    $display("FAIL wide regrant: en,gnt=%b expected=10001", {fsm_enable, gnt});
                end
            end
            if (c == 9) err_clr = 1'b1;
            if (c == 10) err_clr = 1'b1;
            if (c == 11) begin
                checks++;
                if ({err, done} !== 5'b1_0001) begin
                    errors++;
                    $display("FAIL err priority: err,done=%b expected=10001", {err, done});
                end
                err_clr = 1'b0;
                req     = '0;
            end
            if (c == 12) err_clr = 1'b1;
            if (c == 13) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL err_clr: err=%b expected=0", err);
                end
                err_clr = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 5) begin
                checks++;
                if ({fsm_enable, gnt} !== 5'b1_0010) begin
                    errors++;
                    $display("FAIL rstmid fire2: en,gnt=%b expected=10010", {fsm_enable, gnt});
                end
            end
            if (c == 6) reset = 1'b1;
            if (c == 7) begin
                checks++;
                if ({fsm_enable, gnt, done, err, busy} !== 11'b0) begin
                    errors++;
                    $display("FAIL rstmid outputs: %b expected=%b", {fsm_enable, gnt, done, err, busy}, 11'b0);
                end
                reset = 1'b0;
                req   = 4'b0011;
            end
            if (c == 8) begin
                checks++;
                if ({gnt, fsm_enable, done} !== 9'b0001_1_0000) begin
                    errors++;
                    $display("FAIL rstmid regrant: gnt,en,done=%b expected=000110000", {gnt, fsm_enable, done});
                end
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_wide_pulse();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
